// File: rtl/sparse_hv_expand.sv
// ----------------------------------------------------------------------------
// sparse_hv_expand : streams set-bit indices into a DIM-bit dense hypervector
//                    and hands it downstream with its ones count.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sparse_hv_expand #(
  parameter int DIM   = 512,
  parameter int IDX_W = 9,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             idx_valid,
  output logic             idx_ready,
  input  logic [IDX_W-1:0] idx,
  input  logic             idx_last,
  output logic             vec_valid,
  input  logic             vec_ready,
  output logic [DIM-1:0]   vec_out,
  output logic [CNT_W-1:0] vec_ones,
  output logic             dup_flag,
  output logic             oor_flag
);

  localparam int SEL_W = $clog2(DIM);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [DIM-1:0]   vec_q, vec_d;
  logic [CNT_W-1:0] ones_q, ones_d;
  logic             dup_q, dup_d;
  logic             oor_q, oor_d;

  logic             w_accept;
  logic             w_in_range;
  logic [SEL_W-1:0] w_sel;

  assign w_accept   = idx_valid && (state_q == FILL);
  // Extra MSB keeps the compare meaningful when 2^IDX_W == DIM.
  assign w_in_range = ({1'b0, idx} < (IDX_W+1)'(DIM));
  assign w_sel      = idx[SEL_W-1:0];

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    ones_d  = ones_q;
    dup_d   = dup_q;
    oor_d   = oor_q;
    case (state_q)
      FILL: begin
        if (w_accept) begin
          if (!w_in_range) begin
            oor_d = 1'b1;
          end else if (vec_q[w_sel]) begin
            dup_d = 1'b1;
          end else begin
            vec_d[w_sel] = 1'b1;
            ones_d       = ones_q + CNT_W'(1);
          end
          if (idx_last) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (vec_ready) begin
          state_d = FILL;
          vec_d   = '0;
          ones_d  = '0;
          dup_d   = 1'b0;
          oor_d   = 1'b0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      vec_q   <= '0;
      ones_q  <= '0;
      dup_q   <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      ones_q  <= ones_d;
      dup_q   <= dup_d;
      oor_q   <= oor_d;
    end
  end

  assign idx_ready = (state_q == FILL);
  assign vec_valid = (state_q == HOLD);
  assign vec_out   = vec_q;
  assign vec_ones  = ones_q;
  assign dup_flag  = dup_q;
  assign oor_flag  = oor_q;

endmodule

`default_nettype wire
